// File: rtl/prefetch_writer_pkg.sv
// ============================================================================
// Module      : prefetch_writer_pkg
// Description : Shared constants, FSM state type and address helper for the
//               instruction prefetch writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prefetch_writer_pkg;

   // Reset vector: execution starts at FFFF:0000
   localparam logic [15:0] RESET_CS = 16'hFFFF;
   localparam logic [15:0] RESET_IP = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } pf_state_e;

   // Word address physical[19:1] of seg:off. Because {seg,4'h0} is always
   // even, bit 0 of the offset never carries into the upper bits, so the
   // word address is seg*8 + off[15:1] taken modulo 2^19.
   function automatic logic [18:0] word_addr(input logic [15:0] seg,
                                             input logic [14:0] off_hi);
      return {seg, 3'b000} + {4'h0, off_hi};
   endfunction

   localparam logic [18:0] RESET_WORD_ADDR = word_addr(RESET_CS, RESET_IP[15:1]);

endpackage

`default_nettype wire

// File: rtl/prefetch_byte_buffer.sv
// ============================================================================
// Module      : prefetch_byte_buffer
// Description : Holds one fetched 16-bit word and streams its bytes (low then
//               high, or high only for an odd start) into the prefetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_byte_buffer
   import prefetch_writer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,       // accept a new word this cycle
   input  logic        odd_i,        // word was fetched for an odd byte address
   input  logic [15:0] word_i,
   input  logic        flush_i,      // redirect: drop remaining bytes, block write
   input  logic        fifo_full_i,
   output logic        wr_en_o,
   output logic [7:0]  wr_data_o,
   output logic        last_o        // final pending byte is written this cycle
);

   logic [15:0] word_q, word_d;
   logic [1:0]  count_q, count_d;
   logic        sel_hi_q, sel_hi_d;

   // A byte leaves only when one is pending, the FIFO has room and no redirect
   always_comb begin
      wr_en_o   = (count_q != 2'd0) && !fifo_full_i && !flush_i;
      wr_data_o = 8'h00;
      if (wr_en_o) begin
         wr_data_o = sel_hi_q ? word_q[15:8] : word_q[7:0];
      end
      last_o = wr_en_o && (count_q == 2'd1);
   end

   // Next-state for word/count/select: flush beats load beats write
   always_comb begin
      word_d   = word_q;
      count_d  = count_q;
      sel_hi_d = sel_hi_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else if (load_i) begin
         word_d   = word_i;
         count_d  = odd_i ? 2'd1 : 2'd2;
         sel_hi_d = odd_i;
      end else if (wr_en_o) begin
         count_d  = count_q - 2'd1;
         sel_hi_d = 1'b1;
      end
   end

   // Buffer state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         word_q   <= 16'h0000;
         count_q  <= 2'd0;
         sel_hi_q <= 1'b0;
      end else begin
         word_q   <= word_d;
         count_q  <= count_d;
         sel_hi_q <= sel_hi_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/prefetch_writer.sv
// ============================================================================
// Module      : prefetch_writer
// Description : Instruction prefetch producer. Fetches words at CS:IP over the
//               memory bus and writes them byte-wise into the prefetch FIFO,
//               handling odd starts, FIFO back-pressure and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_writer
   import prefetch_writer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_new_ip_i,
   input  logic [15:0] new_cs_i,
   input  logic [15:0] new_ip_i,
   output logic        mem_access_o,
   input  logic        mem_ack_i,
   output logic [18:0] mem_address_o,
   input  logic [15:0] mem_data_i,
   output logic        fifo_wr_en_o,
   output logic [7:0]  fifo_wr_data_o,
   input  logic        fifo_full_i,
   output logic        fifo_reset_o
);

   pf_state_e   state_q, state_d;
   logic [15:0] cs_q, cs_d;
   logic [15:0] ip_q, ip_d;
   logic [18:0] req_addr_q, req_addr_d;
   logic        discard_q, discard_d;

   logic        ack_valid;
   logic        buf_load;
   logic        buf_last;

   // An ack only counts while a request is outstanding; a word is kept only
   // if it was not invalidated by an earlier or coincident redirect.
   assign ack_valid = (state_q == ST_REQ) && mem_ack_i;
   assign buf_load  = ack_valid && !discard_q && !load_new_ip_i;

   prefetch_byte_buffer u_byte_buffer (
      .clk         (clk),
      .reset       (reset),
      .load_i      (buf_load),
      .odd_i       (ip_q[0]),
      .word_i      (mem_data_i),
      .flush_i     (load_new_ip_i),
      .fifo_full_i (fifo_full_i),
      .wr_en_o     (fifo_wr_en_o),
      .wr_data_o   (fifo_wr_data_o),
      .last_o      (buf_last)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: the last byte write or a redirect goes straight back to
   // REQ so the next fetch starts on the following cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (mem_ack_i) begin
               state_d = (discard_q || load_new_ip_i) ? ST_IDLE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (load_new_ip_i || buf_last) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: bus request is the REQ state; FIFO flush follows the strobe
   always_comb begin
      mem_access_o  = (state_q == ST_REQ);
      mem_address_o = req_addr_q;
      fifo_reset_o  = load_new_ip_i;
   end

   // Pointer, discard flag and latched request address next-state
   always_comb begin
      cs_d       = cs_q;
      ip_d       = ip_q;
      discard_d  = discard_q;
      req_addr_d = req_addr_q;
      if (load_new_ip_i) begin
         cs_d = new_cs_i;
         ip_d = new_ip_i;
         // A request still in flight must complete; its data is dropped
         if (state_q == ST_REQ) begin
            discard_d = !mem_ack_i;
         end
      end else if (buf_load) begin
         ip_d = ip_q + (ip_q[0] ? 16'd1 : 16'd2);
      end else if (ack_valid) begin
         discard_d = 1'b0;
      end
      // Address is captured once on REQ entry and held until the ack
      if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
         req_addr_d = word_addr(cs_d, ip_d[15:1]);
      end
   end

   // Pointer and request registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_q       <= RESET_CS;
         ip_q       <= RESET_IP;
         req_addr_q <= RESET_WORD_ADDR;
         discard_q  <= 1'b0;
      end else begin
         cs_q       <= cs_d;
         ip_q       <= ip_d;
         req_addr_q <= req_addr_d;
         discard_q  <= discard_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_prefetch_writer.sv
// ============================================================================
// Module      : tb_prefetch_writer
// Description : Self-checking bench for prefetch_writer. Expected FIFO bytes
//               are queued by the stimulus; a monitor pops them on each write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prefetch_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_new_ip;
   logic [15:0] new_cs;
   logic [15:0] new_ip;
   logic        mem_access;
   logic        mem_ack;
   logic [18:0] mem_address;
   logic [15:0] mem_data;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic        fifo_full;
   logic        fifo_reset;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  mon_exp;

   always #5 clk = ~clk;

   prefetch_writer dut (
      .clk            (clk),
      .reset          (reset),
      .load_new_ip_i  (load_new_ip),
      .new_cs_i       (new_cs),
      .new_ip_i       (new_ip),
      .mem_access_o   (mem_access),
      .mem_ack_i      (mem_ack),
      .mem_address_o  (mem_address),
      .mem_data_i     (mem_data),
      .fifo_wr_en_o   (fifo_wr_en),
      .fifo_wr_data_o (fifo_wr_data),
      .fifo_full_i    (fifo_full),
      .fifo_reset_o   (fifo_reset)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every FIFO write must match the oldest expected byte
   always @(negedge clk) begin
      if (!reset && fifo_wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL stray_byte actual=%h expected=none", fifo_wr_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("fifo_byte", {24'h0, fifo_wr_data}, {24'h0, mon_exp});
         end
      end
   end

   // Wait (bounded) for a bus request and check its address
   task automatic wait_req(input logic [18:0] a, input string nm);
      int n = 0;
      @(negedge clk);
      while (!mem_access && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_req_seen"}, {31'h0, mem_access}, 32'h1);
      chk({nm, "_addr"}, {13'h0, mem_address}, {13'h0, a});
   endtask

   // One fetch: nb bytes expected (2 even, 1 odd = high byte), optional stall
   task automatic fetch(input logic [18:0] a, input logic [15:0] d, input int nb,
                        input int full_cyc, input string nm);
      logic [15:0] w;
      w = d;
      wait_req(a, nm);
      if (nb == 2) begin
         exp_q.push_back(w[7:0]);
         exp_q.push_back(w[15:8]);
      end else begin
         exp_q.push_back(w[15:8]);
      end
      @(posedge clk); #1;
      mem_ack   = 1'b1;
      mem_data  = d;
      fifo_full = (full_cyc > 0);
      @(posedge clk); #1;
      mem_ack  = 1'b0;
      mem_data = 16'h0000;
      if (full_cyc > 0) begin
         for (int i = 0; i < full_cyc; i++) begin
            @(negedge clk);
            chk({nm, "_stall"}, {31'h0, fifo_wr_en}, 32'h0);
         end
         @(posedge clk); #1;
         fifo_full = 1'b0;
      end else begin
         for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            chk({nm, "_wr_timing"}, {31'h0, fifo_wr_en}, 32'h1);
         end
         @(negedge clk);
         chk({nm, "_next_req_timing"}, {31'h0, mem_access}, 32'h1);
      end
   endtask

   initial begin
      reset       = 1'b1;
      load_new_ip = 1'b0;
      new_cs      = 16'h0000;
      new_ip      = 16'h0000;
      mem_ack     = 1'b0;
      mem_data    = 16'h0000;
      fifo_full   = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_mem_access", {31'h0, mem_access}, 32'h0);
      chk("rst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
      chk("rst_fifo_reset", {31'h0, fifo_reset}, 32'h0);
      chk("rst_wr_data", {24'h0, fifo_wr_data}, 32'h0);
      chk("rst_mem_address", {13'h0, mem_address}, {13'h0, 19'h7FFF8});

      // Release: no request in cycle 0, request in cycle 1
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rel_cycle0_idle", {31'h0, mem_access}, 32'h0);
      @(negedge clk);
      chk("rel_cycle1_req", {31'h0, mem_access}, 32'h1);

      // First fetch at FFFF:0000 -> AA, BB; next at FFFF:0002
      fetch(19'h7FFF8, 16'hBBAA, 2, 0, "reset_fetch");

      // Redirect while request at 7FFF9 pending: address held, word dropped
      wait_req(19'h7FFF9, "pending");
      @(posedge clk); #1;
      load_new_ip = 1'b1;
      new_cs      = 16'h1000;
      new_ip      = 16'h0003;
      @(negedge clk);
      chk("pend_fifo_reset", {31'h0, fifo_reset}, 32'h1);
      chk("pend_req_held", {31'h0, mem_access}, 32'h1);
      chk("pend_addr_held", {13'h0, mem_address}, {13'h0, 19'h7FFF9});
      @(posedge clk); #1;
      load_new_ip = 1'b0;
      @(negedge clk);
      chk("pend_fifo_reset_off", {31'h0, fifo_reset}, 32'h0);
      chk("pend_addr_held2", {13'h0, mem_address}, {13'h0, 19'h7FFF9});
      @(posedge clk); #1;
      mem_ack  = 1'b1;
      mem_data = 16'hDEAD;
      @(posedge clk); #1;
      mem_ack  = 1'b0;
      mem_data = 16'h0000;

      // 1000:0003 is odd: only the high byte 22
      fetch(19'h08001, 16'h2211, 1, 0, "odd_fetch");

      // fetch_ip now 0004; FIFO full for 3 cycles after the ack
      fetch(19'h08002, 16'h5544, 2, 3, "full_stall");

      // Redirect during drain after the low byte: high byte must not appear
      wait_req(19'h08003, "drain_redirect");
      exp_q.push_back(8'h66);
      @(posedge clk); #1;
      mem_ack  = 1'b1;
      mem_data = 16'h7766;
      @(posedge clk); #1;
      mem_ack  = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      load_new_ip = 1'b1;
      new_cs      = 16'hF000;
      new_ip      = 16'hFFFE;
      @(negedge clk);
      chk("drain_fifo_reset", {31'h0, fifo_reset}, 32'h1);
      chk("drain_no_write", {31'h0, fifo_wr_en}, 32'h0);
      @(posedge clk); #1;
      load_new_ip = 1'b0;
      @(negedge clk);
      chk("redirect_req_next", {31'h0, mem_access}, 32'h1);
      chk("redirect_addr", {13'h0, mem_address}, {13'h0, 19'h7FFFF});

      // F000:FFFE then offset wraps to F000:0000
      fetch(19'h7FFFF, 16'h9988, 2, 0, "wrap_fetch");

      // Ack coincident with redirect to 2000:0010: word dropped
      wait_req(19'h78000, "wrapped");
      @(posedge clk); #1;
      mem_ack     = 1'b1;
      mem_data    = 16'h1234;
      load_new_ip = 1'b1;
      new_cs      = 16'h2000;
      new_ip      = 16'h0010;
      @(negedge clk);
      chk("coinc_fifo_reset", {31'h0, fifo_reset}, 32'h1);
      chk("coinc_no_write", {31'h0, fifo_wr_en}, 32'h0);
      @(posedge clk); #1;
      mem_ack     = 1'b0;
      load_new_ip = 1'b0;
      fetch(19'h10008, 16'hABCD, 2, 0, "coinc_new_ptr");

      // Reset overrides an in-flight request
      wait_req(19'h10009, "inflight");
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("inflight_rst_access", {31'h0, mem_access}, 32'h0);
      chk("inflight_rst_addr", {13'h0, mem_address}, {13'h0, 19'h7FFF8});
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("leftover_bytes", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
